parking_gate_controller: RTL and testbench
==========================================

// Module: parking_gate_controller
// PURPOSE
//   Sequences the parking-lot gate and owns the slot-occupancy register.
//   Accepts entry/exit requests, arbitrates between them, allocates the
//   lowest-index free slot on entry, frees the slot on exit, and drives the
//   gate with a passage timeout. Sits between gate sensors/buttons and the
//   display/status logic.
// PARAMETERS
//   NUM_SLOTS     8    number of parking slots (NUM_SLOTS <= 2**IDX_W)
//   IDX_W         3    width of slot index
//   GATE_TIMEOUT  16   max cycles gate stays open waiting for car_passed (>=2)
// PORTS
//   clk            in   1          rising-edge clock
//   reset          in   1          synchronous, active-high reset
//   entry_req      in   1          1-cycle pulse: car at entry gate
//   exit_req       in   1          1-cycle pulse: car at exit gate
//   exit_slot      in   IDX_W      slot index being vacated, valid with exit_req
//   car_passed     in   1          gate sensor: car cleared the gate
//   gate_open      out  1          gate actuator, 1 = open
//   assign_valid   out  1          1-cycle pulse: assigned_slot is new
//   assigned_slot  out  IDX_W      slot allocated to the entering car
//   exit_err       out  1          1-cycle pulse: exit_req on free/out-of-range slot
//   busy           out  1          1 whenever state != IDLE
//   full           out  1          all slots occupied
//   free_count     out  IDX_W+1    number of free slots
//   occupancy      out  NUM_SLOTS  bit i = 1 -> slot i occupied or reserved
// BEHAVIOUR
//   Reset: state IDLE, occupancy 0, gate_open 0, assign_valid 0,
//     assigned_slot 0, exit_err 0, busy 0, full 0, free_count NUM_SLOTS.
//     Reset mid-operation clears everything incl. occupancy, gate closes next cycle.
//   All outputs registered. full/free_count track occupancy in same cycle it updates.
//   States: IDLE, ENTRY_OPEN, EXIT_OPEN, CLOSE.
//   IDLE (requests sampled only here; ignored silently in other states):
//     - exit_req, exit_slot < NUM_SLOTS and occupied -> EXIT_OPEN, latch slot.
//       Exit has priority: a coincident entry_req is dropped.
//     - exit_req on free or out-of-range slot -> exit_err=1 for one cycle;
//       coincident entry_req then processed normally.
//     - entry_req, not full -> pick lowest-index 0 bit of occupancy, set it
//       (reservation), assigned_slot=index, assign_valid=1 one cycle -> ENTRY_OPEN.
//     - entry_req while full -> ignored, no pulse, stay IDLE.
//   Latency: request at edge N -> gate_open=1 (and assign_valid) after edge N+1.
//   ENTRY_OPEN / EXIT_OPEN: gate_open=1; timer cleared on entry, +1 per cycle.
//     - car_passed: ENTRY keeps slot occupied; EXIT clears latched slot bit -> CLOSE.
//     - no car_passed after GATE_TIMEOUT cycles open: ENTRY releases reserved
//       bit; EXIT leaves slot occupied -> CLOSE. gate_open high exactly
//       GATE_TIMEOUT cycles in that case.
//     - car_passed on the timeout cycle: car_passed wins.
//   CLOSE: gate_open=0, busy=1, one cycle -> IDLE (guaranteed gate-closed gap).
//   car_passed outside OPEN states ignored. Timer never wraps.
// TESTING
//   1. reset; entry_req pulse -> next cycle assign_valid=1, assigned_slot=0,
//      gate_open=1, occupancy=8'h01, free_count=7; car_passed -> CLOSE, IDLE.
//   2. 8 entry+pass sequences -> slots 0..7 in order, occupancy=8'hFF, full=1,
//      free_count=0; 9th entry_req -> no assign_valid, gate_open stays 0.
//   3. full lot; exit_req slot 3 + car_passed -> occupancy=8'hF7, full=0;
//      next entry_req -> assigned_slot=3.
//   4. entry_req and valid exit_req (slot 0) same cycle -> EXIT_OPEN, no
//      assign_valid; exit_req slot 5 while slot 5 free -> exit_err one cycle.
//   5. entry_req, no car_passed -> gate_open high exactly 16 cycles, then
//      reserved bit cleared, free_count restored; requests during busy ignored.
//   6. reset asserted in ENTRY_OPEN -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Parking gate sequencer: arbitrates entry/exit requests, allocates the lowest
// free slot, owns the occupancy register and times out an unused open gate.
module parking_gate_controller #(
  parameter int NUM_SLOTS    = 8,
  parameter int IDX_W        = 3,
  parameter int GATE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [IDX_W-1:0]     exit_slot,
  input  logic                 car_passed,
  output logic                 gate_open,
  output logic                 assign_valid,
  output logic [IDX_W-1:0]     assigned_slot,
  output logic                 exit_err,
  output logic                 busy,
  output logic                 full,
  output logic [IDX_W:0]       free_count,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [1:0]           dbg_state
);

  localparam int TMR_W = (GATE_TIMEOUT > 2) ? $clog2(GATE_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2,
    CLOSE      = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     slot_q, slot_nxt;
  logic [TMR_W-1:0]     timer_q, timer_nxt;
  logic [NUM_SLOTS-1:0] occ_nxt;
  logic                 assign_nxt, exit_err_nxt;
  logic [IDX_W-1:0]     aslot_nxt;
  logic [IDX_W:0]       free_cnt_nxt;
  logic [IDX_W-1:0]     free_idx;
  logic                 free_found;
  logic                 exit_hit;

  assign dbg_state = state;

  // Requests are single-cycle pulses with no back-pressure: they are acted on
  // only while IDLE, and any request arriving while busy is silently dropped.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
    exit_hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (exit_slot == IDX_W'(i) && occupancy[i]) exit_hit = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    occ_nxt      = occupancy;
    slot_nxt     = slot_q;
    timer_nxt    = timer_q;
    assign_nxt   = 1'b0;
    aslot_nxt    = assigned_slot;
    exit_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (exit_req && exit_hit) begin
          state_nxt = EXIT_OPEN;
          slot_nxt  = exit_slot;
        end else begin
          if (exit_req) exit_err_nxt = 1'b1;
          if (entry_req && free_found) begin
            occ_nxt[free_idx] = 1'b1;
            slot_nxt          = free_idx;
            aslot_nxt         = free_idx;
            assign_nxt        = 1'b1;
            state_nxt         = ENTRY_OPEN;
          end
        end
      end
      ENTRY_OPEN: begin
        if (car_passed) begin
          state_nxt = CLOSE;
        end else if (timer_q == TMR_LAST) begin
          occ_nxt[slot_q] = 1'b0;
          state_nxt       = CLOSE;
        end else begin
          timer_nxt = timer_q + TMR_W'(1);
        end
      end
      EXIT_OPEN: begin
        if (car_passed) begin
          occ_nxt[slot_q] = 1'b0;
          state_nxt       = CLOSE;
        end else if (timer_q == TMR_LAST) begin
          state_nxt = CLOSE;
        end else begin
          timer_nxt = timer_q + TMR_W'(1);
        end
      end
      CLOSE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Status outputs are derived from the next occupancy so they move together.
    free_cnt_nxt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occ_nxt[i]) free_cnt_nxt = free_cnt_nxt + (IDX_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      slot_q        <= '0;
      timer_q       <= '0;
      occupancy     <= '0;
      gate_open     <= 1'b0;
      assign_valid  <= 1'b0;
      assigned_slot <= '0;
      exit_err      <= 1'b0;
      busy          <= 1'b0;
      full          <= 1'b0;
      free_count    <= (IDX_W + 1)'(NUM_SLOTS);
    end else begin
      state         <= state_nxt;
      slot_q        <= slot_nxt;
      timer_q       <= timer_nxt;
      occupancy     <= occ_nxt;
      gate_open     <= (state_nxt == ENTRY_OPEN) || (state_nxt == EXIT_OPEN);
      assign_valid  <= assign_nxt;
      assigned_slot <= aslot_nxt;
      exit_err      <= exit_err_nxt;
      busy          <= (state_nxt != IDLE);
      full          <= &occ_nxt;
      free_count    <= free_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed scenarios with literal checks,
// then random traffic compared every cycle against a transaction-level model.
module tb_parking_gate_controller;

  localparam int NUM = 8;
  localparam int IW  = 3;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          entry_req = 1'b0;
  logic          exit_req = 1'b0;
  logic [IW-1:0] exit_slot = '0;
  logic          car_passed = 1'b0;
  logic          gate_open, assign_valid, exit_err, busy, full;
  logic [IW-1:0] assigned_slot;
  logic [IW:0]   free_count;
  logic [NUM-1:0] occupancy;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  parking_gate_controller #(.NUM_SLOTS(NUM), .IDX_W(IW), .GATE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .car_passed(car_passed), .gate_open(gate_open),
    .assign_valid(assign_valid), .assigned_slot(assigned_slot), .exit_err(exit_err),
    .busy(busy), .full(full), .free_count(free_count), .occupancy(occupancy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // behavioural model: lot contents plus the current gate transaction
  logic [NUM-1:0] m_occ = '0;
  bit             m_gate = 0, m_closing = 0, m_is_exit = 0, m_av = 0, m_err = 0;
  int             m_open_cnt = 0;
  logic [IW-1:0]  m_slot = '0, m_aslot = '0;
  int             k;
  logic [IW-1:0]  exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_occ = '0; m_gate = 0; m_closing = 0; m_av = 0; m_err = 0; m_aslot = '0;
      exp_q.delete();
    end else begin
      m_av = 0; m_err = 0;
      if (m_closing) begin
        m_closing = 0;
      end else if (m_gate) begin
        m_open_cnt++;
        if (car_passed) begin
          if (m_is_exit) m_occ[m_slot] = 1'b0;
          m_gate = 0; m_closing = 1;
        end else if (m_open_cnt == TO) begin
          if (!m_is_exit) m_occ[m_slot] = 1'b0;
          m_gate = 0; m_closing = 1;
        end
      end else begin
        if (exit_req && int'(exit_slot) < NUM && m_occ[exit_slot]) begin
          m_gate = 1; m_is_exit = 1; m_slot = exit_slot; m_open_cnt = 0;
        end else begin
          if (exit_req) m_err = 1;
          if (entry_req && m_occ != {NUM{1'b1}}) begin
            k = 0;
            while (m_occ[k]) k++;
            m_occ[k] = 1'b1;
            m_slot = IW'(k); m_aslot = IW'(k); m_av = 1;
            m_gate = 1; m_is_exit = 0; m_open_cnt = 0;
            exp_q.push_back(IW'(k));
          end
        end
      end
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gate_open", gate_open, m_gate);
      chk("busy", busy, m_gate | m_closing);
      chk("occupancy", occupancy, m_occ);
      chk("free_count", free_count, NUM - $countones(m_occ));
      chk("full", full, m_occ == {NUM{1'b1}});
      chk("assign_valid", assign_valid, m_av);
      chk("assigned_slot", assigned_slot, m_aslot);
      chk("exit_err", exit_err, m_err);
      if (assign_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_slot: got assign of %0d expected none", assigned_slot);
        end else begin
          chk("sb_slot", assigned_slot, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks: return on the negedge where the request's effect is visible
  task automatic req(input logic en, input logic ex, input logic [IW-1:0] slot);
    @(negedge clk);
    entry_req = en; exit_req = ex; exit_slot = slot;
    @(negedge clk);
    entry_req = 0; exit_req = 0;
  endtask

  task automatic pass_car();
    car_passed = 1;
    @(negedge clk);
    car_passed = 0;
    @(negedge clk);
  endtask

  int open_cycles;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_free", free_count, 8);
    chk("rst_occ", occupancy, 0);
    reset = 0;

    // first entry
    req(1, 0, 0);
    chk("t1_av", assign_valid, 1);
    chk("t1_slot", assigned_slot, 0);
    chk("t1_gate", gate_open, 1);
    chk("t1_occ", occupancy, 8'h01);
    chk("t1_free", free_count, 7);
    pass_car();

    // fill the lot
    for (int i = 1; i < NUM; i++) begin
      req(1, 0, 0);
      chk("t2_slot", assigned_slot, i);
      pass_car();
    end
    chk("t2_occ", occupancy, 8'hFF);
    chk("t2_full", full, 1);
    chk("t2_free", free_count, 0);
    req(1, 0, 0);
    chk("t2_noav", assign_valid, 0);
    chk("t2_nogate", gate_open, 0);

    // exit slot 3 then re-enter
    req(0, 1, 3);
    chk("t3_gate", gate_open, 1);
    pass_car();
    chk("t3_occ", occupancy, 8'hF7);
    chk("t3_full", full, 0);
    req(1, 0, 0);
    chk("t3_slot", assigned_slot, 3);
    pass_car();

    // arbitration and exit errors
    req(0, 1, 6);
    pass_car();
    chk("t4_occ_a", occupancy, 8'hBF);
    req(1, 1, 0);
    chk("t4_noav", assign_valid, 0);
    chk("t4_gate", gate_open, 1);
    pass_car();
    chk("t4_occ_b", occupancy, 8'hBE);
    req(0, 1, 6);
    chk("t4_err", exit_err, 1);
    chk("t4_err_gate", gate_open, 0);
    @(negedge clk);
    chk("t4_err_end", exit_err, 0);
    req(1, 1, 6);
    chk("t4_err2", exit_err, 1);
    chk("t4_av2", assign_valid, 1);
    chk("t4_slot2", assigned_slot, 0);
    pass_car();

    // timeout with requests arriving while busy
    @(negedge clk);
    entry_req = 1;
    open_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      entry_req = (i == 4); exit_req = (i == 4); exit_slot = 1;
      if (gate_open) open_cycles++;
    end
    chk("t5_open_cycles", open_cycles, TO);
    chk("t5_occ", occupancy, 8'hBF);
    chk("t5_free", free_count, 1);

    // reset in the middle of an open entry
    req(1, 0, 0);
    chk("t6_gate_pre", gate_open, 1);
    reset = 1;
    @(negedge clk);
    chk("t6_gate", gate_open, 0);
    chk("t6_busy", busy, 0);
    chk("t6_occ", occupancy, 0);
    chk("t6_free", free_count, 8);
    chk("t6_slot", assigned_slot, 0);
    reset = 0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      entry_req  = ($urandom_range(0, 3) == 0);
      exit_req   = ($urandom_range(0, 4) == 0);
      exit_slot  = IW'($urandom_range(0, NUM - 1));
      car_passed = ($urandom_range(0, 5) == 0);
      reset      = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    entry_req = 0; exit_req = 0; car_passed = 0; reset = 0;
    repeat (TO + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
